// File: rtl/anton_neopixel_frame_scheduler_if.sv
// ---------------------------------------------------------------------------
// anton_neopixel_frame_scheduler_if
// Command, configuration, stream-handshake and status signals of the neopixel
// frame scheduler, all in the clk6_4mhz domain.
//   master : register block / stream logic side (drives cmd*, cfg*, stream acks)
//   slave  : frame scheduler side (drives control levels and status)
// ---------------------------------------------------------------------------
interface anton_neopixel_frame_scheduler_if #(
   parameter int unsigned FRAME_BITS = 16,
   parameter int unsigned GAP_BITS   = 16
);
   // software commands and configuration
   logic                  cmdStart;
   logic                  cmdStop;
   logic                  cmdInit;
   logic                  cfgLoop;
   logic [FRAME_BITS-1:0] cfgFrames;
   logic [GAP_BITS-1:0]   cfgFrameGap;

   // stream logic handshake
   logic                  initSlowDone;
   logic                  streamPixelOf;
   logic                  streamSyncOf;
   logic                  initSlow;
   logic                  ctrlInit;
   logic                  ctrlRun;

   // status
   logic                  busy;
   logic                  frameDone;
   logic [FRAME_BITS-1:0] frameCount;
   logic                  initError;
   logic [2:0]            state;

   modport master (
      output cmdStart, cmdStop, cmdInit, cfgLoop, cfgFrames, cfgFrameGap,
      output initSlowDone, streamPixelOf, streamSyncOf,
      input  initSlow, ctrlInit, ctrlRun,
      input  busy, frameDone, frameCount, initError, state
   );

   modport slave (
      input  cmdStart, cmdStop, cmdInit, cfgLoop, cfgFrames, cfgFrameGap,
      input  initSlowDone, streamPixelOf, streamSyncOf,
      output initSlow, ctrlInit, ctrlRun,
      output busy, frameDone, frameCount, initError, state
   );
endinterface

// File: rtl/anton_neopixel_frame_scheduler.sv
// ---------------------------------------------------------------------------
// anton_neopixel_frame_scheduler
// Frame-level sequencer for the neopixel stream datapath. Turns start / stop /
// re-init commands into the ctrlInit / ctrlRun levels, runs the initSlow
// handshake with a timeout, and schedules single, looped and frame-count
// limited transmission with an optional idle gap between frames.
// Ports:
//   clk6_4mhz : datapath clock
//   rst       : synchronous active-high reset
//   bus       : scheduler side of the command / stream / status interface
// Every output is a flop; control levels are registered from the next state.
// ---------------------------------------------------------------------------
module anton_neopixel_frame_scheduler #(
   parameter int unsigned FRAME_BITS   = 16,
   parameter int unsigned GAP_BITS     = 16,
   parameter int unsigned INIT_TIMEOUT = 15
) (
   input logic                            clk6_4mhz,
   input logic                            rst,
   anton_neopixel_frame_scheduler_if.slave bus
);

   localparam int unsigned INIT_CNT_BITS = $clog2(INIT_TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      INIT = 3'd1,
      RUN  = 3'd2,
      SYNC = 3'd3,
      GAP  = 3'd4
   } stateT;

   stateT                    stateReg, stateNext;
   logic [FRAME_BITS-1:0]    frameCountReg, frameCountNext, frameCountInc;
   logic [GAP_BITS-1:0]      gapCountReg, gapCountNext;
   logic [INIT_CNT_BITS-1:0] initCountReg, initCountNext;
   logic                     startPendingReg, startPendingNext;
   logic                     stopPendingReg, stopPendingNext;
   logic                     initPendingReg, initPendingNext;
   logic                     initErrorReg, initErrorNext;
   logic                     frameDoneReg, frameDoneNext;
   logic                     initSlowReg, initSlowNext;
   logic                     ctrlRunReg, ctrlInitReg, busyReg;
   logic                     stopSeen, initSeen;

   // Next-state and bookkeeping decode
   always_comb begin
      stateNext        = stateReg;
      frameCountNext   = frameCountReg;
      gapCountNext     = gapCountReg;
      initCountNext    = initCountReg;
      startPendingNext = startPendingReg;
      stopPendingNext  = stopPendingReg;
      initPendingNext  = initPendingReg;
      initErrorNext    = initErrorReg;
      frameDoneNext    = 1'b0;
      initSlowNext     = 1'b0;
      frameCountInc    = frameCountReg + FRAME_BITS'(1);
      // a command landing in the frame-end cycle is honoured, not lost
      stopSeen         = stopPendingReg | bus.cmdStop;
      initSeen         = initPendingReg | bus.cmdInit;

      case (stateReg)
         IDLE: begin
            // stop dominates any other command issued in the same cycle
            if (bus.cmdStop) begin
               stateNext = IDLE;
            end else if (bus.cmdStart) begin
               stateNext        = INIT;
               startPendingNext = 1'b1;
               frameCountNext   = '0;
               initErrorNext    = 1'b0;
            end else if (bus.cmdInit) begin
               stateNext        = INIT;
               startPendingNext = 1'b0;
            end
         end

         INIT: begin
            if (bus.cmdStop) begin
               startPendingNext = 1'b0;
            end
            if (bus.initSlowDone) begin
               stateNext = (startPendingReg && !bus.cmdStop) ? RUN : IDLE;
            end else if (initCountReg == INIT_CNT_BITS'(INIT_TIMEOUT - 1)) begin
               stateNext     = IDLE;
               initErrorNext = 1'b1;
            end else begin
               initCountNext = initCountReg + INIT_CNT_BITS'(1);
            end
         end

         RUN: begin
            if (bus.cmdStop) stopPendingNext = 1'b1;
            if (bus.cmdInit) initPendingNext = 1'b1;
            if (bus.streamPixelOf) begin
               stateNext = SYNC;
            end
         end

         SYNC: begin
            if (bus.cmdStop) stopPendingNext = 1'b1;
            if (bus.cmdInit) initPendingNext = 1'b1;
            if (bus.streamSyncOf) begin
               frameDoneNext   = 1'b1;
               frameCountNext  = frameCountInc;
               stopPendingNext = 1'b0;
               initPendingNext = 1'b0;
               // frame-end decision, first matching row wins
               if (stopSeen) begin
                  stateNext = IDLE;
               end else if (!bus.cfgLoop) begin
                  stateNext = IDLE;
               end else if ((bus.cfgFrames != '0) && (frameCountInc == bus.cfgFrames)) begin
                  stateNext = IDLE;
               end else if (initSeen) begin
                  stateNext        = INIT;
                  startPendingNext = 1'b1;
               end else if (bus.cfgFrameGap == '0) begin
                  stateNext = RUN;
               end else begin
                  stateNext    = GAP;
                  gapCountNext = bus.cfgFrameGap;
               end
            end
         end

         GAP: begin
            if (bus.cmdInit) initPendingNext = 1'b1;
            if (bus.cmdStop) begin
               stateNext = IDLE;
            end else begin
               gapCountNext = gapCountReg - GAP_BITS'(1);
               if (gapCountReg <= GAP_BITS'(1)) begin
                  stateNext = RUN;
               end
            end
         end

         default: begin
            stateNext = IDLE;
         end
      endcase

      // pending flags never survive a return to IDLE
      if (stateNext == IDLE) begin
         startPendingNext = 1'b0;
         stopPendingNext  = 1'b0;
         initPendingNext  = 1'b0;
      end

      // fresh INIT entry: restart timeout and issue the one-cycle request
      if ((stateNext == INIT) && (stateReg != INIT)) begin
         initCountNext = '0;
         initSlowNext  = 1'b1;
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge clk6_4mhz) begin
      if (rst) begin
         stateReg        <= IDLE;
         frameCountReg   <= '0;
         gapCountReg     <= '0;
         initCountReg    <= '0;
         startPendingReg <= 1'b0;
         stopPendingReg  <= 1'b0;
         initPendingReg  <= 1'b0;
         initErrorReg    <= 1'b0;
         frameDoneReg    <= 1'b0;
         initSlowReg     <= 1'b0;
         ctrlRunReg      <= 1'b0;
         ctrlInitReg     <= 1'b0;
         busyReg         <= 1'b0;
      end else begin
         stateReg        <= stateNext;
         frameCountReg   <= frameCountNext;
         gapCountReg     <= gapCountNext;
         initCountReg    <= initCountNext;
         startPendingReg <= startPendingNext;
         stopPendingReg  <= stopPendingNext;
         initPendingReg  <= initPendingNext;
         initErrorReg    <= initErrorNext;
         frameDoneReg    <= frameDoneNext;
         initSlowReg     <= initSlowNext;
         // levels track the registered state exactly, one flop each
         ctrlRunReg      <= (stateNext == RUN) || (stateNext == SYNC);
         ctrlInitReg     <= (stateNext == INIT);
         busyReg         <= (stateNext != IDLE);
      end
   end

   assign bus.state      = stateReg;
   assign bus.frameCount = frameCountReg;
   assign bus.initError  = initErrorReg;
   assign bus.frameDone  = frameDoneReg;
   assign bus.initSlow   = initSlowReg;
   assign bus.ctrlRun    = ctrlRunReg;
   assign bus.ctrlInit   = ctrlInitReg;
   assign bus.busy       = busyReg;

endmodule
